univ_shift_register: RTL and testbench
======================================

Name: univ_shift_register

Overview:
- Parametrised universal shift register; successor to the fixed 8-bit serial-in shift register.
- Supports hold, shift right, shift left and parallel load, with serial outputs at both ends.
- Tracks the number of shifts since the last load and flags when a full word has been shifted out.
- Used as serializer/deserializer front-end and general data staging in the datapath.

Parameters:
- WIDTH, 8, register width in bits (legal range >= 2).
- RESET_VAL, {WIDTH{1'b0}}, value of q after reset.
- CNT_W, $clog2(WIDTH+1), width of shift counter (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  clock enable. 0 freezes all state.
- mode  input  2  operation select (see Behaviour).
- sin_r  input  1  serial input entering at q[WIDTH-1] on shift right.
- sin_l  input  1  serial input entering at q[0] on shift left.
- pdata  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_r  output  1  equals q[0] (combinational from q).
- sout_l  output  1  equals q[WIDTH-1] (combinational from q).
- shift_cnt  output  CNT_W  shifts since last load/reset, saturating at WIDTH.
- done  output  1  one-cycle pulse when shift_cnt reaches WIDTH.

Behaviour:
- Reset is asynchronous and active-high:
  - On assertion, immediately q=RESET_VAL, shift_cnt=0, done=0, independent of clk.
  - While reset is high, state holds at reset values and inputs are ignored.
- All state updates happen on the rising clk edge only when en=1 and reset=0. With en=0: q and shift_cnt hold, done=0 on the next edge.
- mode encoding:
  - 2'b00 HOLD: q unchanged, shift_cnt unchanged.
  - 2'b01 SHR: q <= {sin_r, q[WIDTH-1:1]}.
  - 2'b10 SHL: q <= {q[WIDTH-2:0], sin_l}.
  - 2'b11 LOAD: q <= pdata, shift_cnt <= 0.
- Latency: one cycle from the edge to q. sout_r/sout_l reflect q in the same cycle, so the bit shifted out on an edge is visible on sout before that edge.
- Counter:
  - SHR or SHL increments shift_cnt if shift_cnt < WIDTH. At WIDTH it saturates and further shifts leave it at WIDTH.
  - done=1 for exactly one cycle after the edge on which shift_cnt goes WIDTH-1 -> WIDTH.
  - done=0 after every other edge, including saturated shifts, HOLD, LOAD and en=0.
- Mixed SHR/SHL sequences all count as shifts. Direction changes do not reset the counter.
- LOAD while shift_cnt=WIDTH clears the counter, and done stays 0.
- sin_r/sin_l may be X when the unused direction is selected. q must not go X from the unused input.
- Undefined mode values (X/Z) are not required to be handled; the bench holds mode at legal values.

Decomposition:
- Package shift_reg_pkg:
  - typedef enum logic [1:0] shift_mode_e {MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD}, with values 0..3 in that order.
  - Used by RTL and bench.
- One sub-module, shift_bit_counter: saturating counter with clear, increment and a terminal pulse (done), parametrised by WIDTH. The data register stays in univ_shift_register.

Test Plan:
1. Reset/X input: reset=1, sin_r=x, pdata=x, clk idle -> after #1: q=8'h00, shift_cnt=0, done=0, with no clock edge required.
2. Load+hold: LOAD pdata=8'hA5, then HOLD 3 cycles -> q=8'hA5 throughout, shift_cnt=0, done=0.
3. Serialize right: LOAD 8'hA5, then SHR x8 with sin_r=0 -> sout_r before each edge reads 1,0,1,0,0,1,0,1. After edge 8: q=8'h00, shift_cnt=8, done=1 for one cycle. A 9th SHR gives shift_cnt=8, done=0.
4. Deserialize left: from q=8'h00, SHL with sin_l=1 -> q=01,03,07,0F,1F,3F,7F,FF. sout_l goes 1 after edge 8, done pulses after edge 8.
5. Enable/freeze: during SHR after 3 shifts, drop en for 4 edges -> q and shift_cnt (=3) frozen. Re-enable, and done pulses after 5 more shifts.
6. Async reset mid-shift: after 5 SHL edges, assert reset between edges -> q=RESET_VAL and shift_cnt=0 within #1, before the next edge. Repeat with WIDTH=4, RESET_VAL=4'hF: q=4'hF, done after 4 shifts.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation select encoding.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_SHR  = 2'd1,
        MODE_SHL  = 2'd2,
        MODE_LOAD = 2'd3
    } shift_mode_e;

endpackage

// File: rtl/shift_bit_counter.sv
// Saturating shift counter: clears on load, counts shifts up to WIDTH and
// pulses done on the single edge where it reaches WIDTH.
module shift_bit_counter #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             done_d, done_q;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (en) begin
            if (clr) begin
                cnt_d = '0;
            end else if (inc && (cnt_q != CNT_MAX)) begin
                cnt_d  = cnt_q + 1'b1;
                // Pulse only on the transition into saturation.
                done_d = (cnt_q == CNT_LAST);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/univ_shift_register.sv
// Parametrised universal shift register: hold, shift right/left, parallel load,
// serial taps at both ends and a shifts-since-load counter with done pulse.
module univ_shift_register
    import shift_reg_pkg::*;
#(
    parameter  int               WIDTH     = 8,
    parameter  logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int               CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    shift_mode_e      mode_e;
    logic [WIDTH-1:0] q_d, q_q;
    logic             is_shift, is_load;

    assign mode_e   = shift_mode_e'(mode);
    assign is_shift = (mode_e == MODE_SHR) || (mode_e == MODE_SHL);
    assign is_load  = (mode_e == MODE_LOAD);

    // Each branch only references its own serial input, so an X on the
    // unused one never reaches q.
    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode_e)
                MODE_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
                MODE_LOAD: q_d = pdata;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= RESET_VAL;
        else       q_q <= q_d;
    end

    shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (is_load),
        .inc   (is_shift),
        .cnt   (shift_cnt),
        .done  (done)
    );

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_register.sv
// Bench for univ_shift_register: an 8-bit and a 4-bit (reset 4'hF) instance share
// stimulus and are checked each cycle against an arithmetic model.
module tb_univ_shift_register;
    import shift_reg_pkg::*;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       chk_on = 1'b0;
    logic       reset, en, sin_r, sin_l;
    logic [1:0] mode;
    logic [7:0] pdata;
    logic [3:0] pdata4;

    logic [7:0] q8;
    logic [3:0] q4;
    logic       sr8, sl8, dn8, sr4, sl4, dn4;
    logic [3:0] cnt8;
    logic [2:0] cnt4;

    int n_cmp = 0;
    int n_err = 0;

    // model state, index 0 = 8-bit instance, 1 = 4-bit instance
    int unsigned mw[2]  = '{8, 4};
    int unsigned mrv[2] = '{32'h0, 32'hF};
    int unsigned mq[2];
    int unsigned mcnt[2];
    bit          mdone[2];

    univ_shift_register #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .pdata(pdata), .q(q8), .sout_r(sr8), .sout_l(sl8), .shift_cnt(cnt8), .done(dn8)
    );

    univ_shift_register #(.WIDTH(4), .RESET_VAL(4'hF)) u4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .pdata(pdata4), .q(q4), .sout_r(sr4), .sout_l(sl4), .shift_cnt(cnt4), .done(dn4)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mq[d] = mrv[d]; mcnt[d] = 0; mdone[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int unsigned mask;
            mask = (32'd1 << mw[d]) - 1;
            if (reset) begin
                mq[d] = mrv[d]; mcnt[d] = 0; mdone[d] = 1'b0;
            end else begin
                mdone[d] = 1'b0;
                if (en) begin
                    if (mode == MODE_LOAD) begin
                        mq[d] = pdata & mask;
                        mcnt[d] = 0;
                    end else if (mode == MODE_SHR || mode == MODE_SHL) begin
                        if (mode == MODE_SHR)
                            mq[d] = (mq[d] >> 1) | ((sin_r === 1'b1) ? (32'd1 << (mw[d] - 1)) : 32'd0);
                        else
                            mq[d] = ((mq[d] << 1) | ((sin_l === 1'b1) ? 32'd1 : 32'd0)) & mask;
                        if (mcnt[d] < mw[d]) begin
                            mcnt[d]++;
                            mdone[d] = (mcnt[d] == mw[d]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                        input logic [7:0] pd);
        en = e; mode = m; sin_r = sr; sin_l = sl; pdata = pd; pdata4 = pd[3:0];
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("u8.q",      32'(q8),   mq[0]);
            chk("u8.cnt",    32'(cnt8), mcnt[0]);
            chk("u8.done",   32'(dn8),  32'(mdone[0]));
            chk("u8.sout_r", 32'(sr8),  mq[0] & 1);
            chk("u8.sout_l", 32'(sl8),  (mq[0] >> 7) & 1);
            chk("u4.q",      32'(q4),   mq[1]);
            chk("u4.cnt",    32'(cnt4), mcnt[1]);
            chk("u4.done",   32'(dn4),  32'(mdone[1]));
            chk("u4.sout_r", 32'(sr4),  mq[1] & 1);
            chk("u4.sout_l", 32'(sl4),  (mq[1] >> 3) & 1);
        end
    end

    initial begin
        logic [7:0] a5_bits;
        logic [7:0] shl_exp [8];
        shl_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

        // Reset with X inputs and no clock edge.
        reset = 1'b1; en = 1'b1; mode = MODE_SHR; sin_r = 1'bx; sin_l = 1'bx;
        pdata = 'x; pdata4 = 'x;
        model_reset();
        #1;
        chk("rst.q8", 32'(q8), 32'h00);
        chk("rst.cnt8", 32'(cnt8), 32'd0);
        chk("rst.done8", 32'(dn8), 32'd0);
        chk("rst.q4", 32'(q4), 32'hF);
        #1 reset = 1'b0;
        mode = MODE_HOLD;
        clk_run = 1'b1;
        chk_on = 1'b1;

        // Load then hold.
        step(1, MODE_LOAD, 1'bx, 1'bx, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            step(1, MODE_HOLD, 1'bx, 1'bx, 8'h00);
            chk("hold.q8", 32'(q8), 32'hA5);
            chk("hold.cnt8", 32'(cnt8), 32'd0);
        end

        // Serialize right: sout_r before each edge walks the bits of A5 LSB first.
        a5_bits = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk("ser.sout_r", 32'(sr8), 32'(a5_bits[i]));
            step(1, MODE_SHR, 1'b0, 1'bx, 8'h00);
            chk("ser.done8", 32'(dn8), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("ser.q8", 32'(q8), 32'h00);
        chk("ser.cnt8", 32'(cnt8), 32'd8);
        step(1, MODE_SHR, 1'b0, 1'bx, 8'h00);
        chk("ser.sat_cnt8", 32'(cnt8), 32'd8);
        chk("ser.sat_done8", 32'(dn8), 32'd0);

        // Load while saturated clears the counter without a done pulse.
        step(1, MODE_LOAD, 1'bx, 1'bx, 8'h00);
        chk("ldsat.cnt8", 32'(cnt8), 32'd0);
        chk("ldsat.done8", 32'(dn8), 32'd0);

        // Deserialize left with sin_l=1.
        for (int i = 0; i < 8; i++) begin
            step(1, MODE_SHL, 1'bx, 1'b1, 8'h00);
            chk("des.q8", 32'(q8), 32'(shl_exp[i]));
            chk("des.sout_l", 32'(sl8), (i == 7) ? 32'd1 : 32'd0);
            chk("des.done8", 32'(dn8), (i == 7) ? 32'd1 : 32'd0);
        end

        // Enable freeze mid-shift.
        step(1, MODE_LOAD, 1'bx, 1'bx, 8'hC3);
        for (int i = 0; i < 3; i++) step(1, MODE_SHR, 1'b1, 1'bx, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(0, MODE_SHR, 1'b0, 1'bx, 8'h00);
            chk("frz.q8", 32'(q8), 32'hF8);
            chk("frz.cnt8", 32'(cnt8), 32'd3);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, MODE_SHR, 1'b0, 1'bx, 8'h00);
            chk("frz.done8", 32'(dn8), (i == 4) ? 32'd1 : 32'd0);
        end

        // Async reset between edges after 5 SHL shifts.
        step(1, MODE_LOAD, 1'bx, 1'bx, 8'h5A);
        for (int i = 0; i < 5; i++) step(1, MODE_SHL, 1'bx, 1'b0, 8'h00);
        #1 reset = 1'b1;
        model_reset();
        #1;
        chk("arst.q8", 32'(q8), 32'h00);
        chk("arst.cnt8", 32'(cnt8), 32'd0);
        chk("arst.q4", 32'(q4), 32'hF);
        chk("arst.cnt4", 32'(cnt4), 32'd0);
        step(1, MODE_SHL, 1'bx, 1'b1, 8'h00);
        chk("arst.hold_q8", 32'(q8), 32'h00);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1, MODE_SHL, 1'bx, 1'b0, 8'h00);
            chk("w4.done4", 32'(dn4), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("w4.q4", 32'(q4), 32'h0);

        // Random traffic; the unused serial input is driven X.
        for (int i = 0; i < 600; i++) begin
            logic [1:0] m;
            logic       e, sr, sl;
            m  = 2'($urandom_range(0, 3));
            e  = ($urandom_range(0, 9) != 0);
            sr = (m == MODE_SHR) ? 1'($urandom_range(0, 1)) : 1'bx;
            sl = (m == MODE_SHL) ? 1'($urandom_range(0, 1)) : 1'bx;
            step(e, m, sr, sl, 8'($urandom));
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                model_reset();
                #2 reset = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
